// File: rtl/camera_pkg.sv
// camera_pkg: shared definitions for the DVP camera emulator.
//   cam_state_t    - frame region / FSM state
//   CAM_FILL_BYTE  - value driven on the byte bus outside href and on underrun
//   cam_line_len() - cycles per line period (two bytes per pixel plus blanking)
package camera_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } cam_state_t;

    localparam logic [7:0] CAM_FILL_BYTE = 8'h00;

    function automatic int cam_line_len(input int h_active, input int h_blank);
        return 2 * h_active + h_blank;
    endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// dvp_timing_gen: frame/line timing for the DVP transmitter.
// Holds the region FSM, the byte counter (0..L-1) and the line counter within
// the current region. Everything is computed one cycle ahead so vsync/href are
// registered and line up with the byte register in the top level.
// Ports:
//   i_clk, i_rst     - clock, asynchronous active-high reset
//   i_enable         - start / continue frames (sampled in IDLE and at frame end)
//   o_state          - current region
//   o_vsync, o_href  - registered sync qualifiers for the current cycle
//   o_fetch          - next cycle carries a high byte (pixel handshake strobe)
//   o_load_low       - next cycle carries a low byte
module dvp_timing_gen
    import camera_pkg::*;
#(
    parameter int H_ACTIVE    = 320,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 240,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    output cam_state_t o_state,
    output logic       o_vsync,
    output logic       o_href,
    output logic       o_fetch,
    output logic       o_load_low
);

    localparam int L      = cam_line_len(H_ACTIVE, H_BLANK);
    localparam int MAX_A  = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int MAX_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int MAX_LN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int BYTE_W = $clog2(L + 1);
    localparam int LINE_W = $clog2(MAX_LN + 1);

    cam_state_t        r_state;
    logic [BYTE_W-1:0] r_byte;
    logic [LINE_W-1:0] r_line;
    logic              r_vsync;
    logic              r_href;

    cam_state_t        w_nstate;
    logic [BYTE_W-1:0] w_nbyte;
    logic [LINE_W-1:0] w_nline;
    logic              w_next_href;

    // Index of the final line of each region.
    function automatic logic [LINE_W-1:0] last_line(input cam_state_t s);
        case (s)
            ST_VSYNC:  return LINE_W'(VSYNC_LINES - 1);
            ST_VBACK:  return LINE_W'(V_BACK - 1);
            ST_ACTIVE: return LINE_W'(V_ACTIVE - 1);
            default:   return LINE_W'(V_FRONT - 1);
        endcase
    endfunction

    function automatic cam_state_t succ(input cam_state_t s, input logic en);
        case (s)
            ST_VSYNC:  return ST_VBACK;
            ST_VBACK:  return ST_ACTIVE;
            ST_ACTIVE: return ST_VFRONT;
            default:   return en ? ST_VSYNC : ST_IDLE;
        endcase
    endfunction

    always_comb begin
        w_nstate = r_state;
        w_nbyte  = r_byte;
        w_nline  = r_line;
        if (r_state == ST_IDLE) begin
            w_nbyte = '0;
            w_nline = '0;
            if (i_enable)
                w_nstate = ST_VSYNC;
        end else if (r_byte == BYTE_W'(L - 1)) begin
            w_nbyte = '0;
            if (r_line == last_line(r_state)) begin
                w_nline  = '0;
                w_nstate = succ(r_state, i_enable);
            end else begin
                w_nline = r_line + 1'b1;
            end
        end else begin
            w_nbyte = r_byte + 1'b1;
        end
    end

    assign w_next_href = (w_nstate == ST_ACTIVE) && (w_nbyte < BYTE_W'(2 * H_ACTIVE));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_byte  <= '0;
            r_line  <= '0;
            r_vsync <= 1'b0;
            r_href  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_byte  <= w_nbyte;
            r_line  <= w_nline;
            r_vsync <= (w_nstate == ST_VSYNC);
            r_href  <= w_next_href;
        end
    end

    // Even byte positions within href are high bytes.
    assign o_fetch    = w_next_href & ~w_nbyte[0];
    assign o_load_low = w_next_href &  w_nbyte[0];
    assign o_state    = r_state;
    assign o_vsync    = r_vsync;
    assign o_href     = r_href;

endmodule

// File: rtl/camera_emulator.sv
// camera_emulator: byte-serial DVP camera transmitter.
// Pulls RGB565 pixels from a valid/ready stream and sends them high byte first,
// one byte per clock, framed by vsync/href. Frames repeat while enable is high.
// Ports:
//   p_clock, reset      - clock, asynchronous active-high reset
//   enable              - run frames
//   in_data, in_valid   - pixel stream input
//   in_ready            - pixel taken on this edge when in_valid is high
//   vsync, href, p_data - DVP output bus (registered, mutually aligned)
//   underrun            - one-cycle pulse: pixel needed, none offered
//   busy                - not IDLE
module camera_emulator
    import camera_pkg::*;
#(
    parameter int H_ACTIVE    = 320,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 240,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        p_clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  p_data,
    output logic        underrun,
    output logic        busy
);

    cam_state_t w_state;
    logic       w_vsync;
    logic       w_href;
    logic       w_fetch;
    logic       w_load_low;

    logic [7:0] r_p_data;
    logic [7:0] r_low;
    logic       r_underrun;

    dvp_timing_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .H_BLANK     (H_BLANK),
        .V_ACTIVE    (V_ACTIVE),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) u_timing (
        .i_clk      (p_clock),
        .i_rst      (reset),
        .i_enable   (enable),
        .o_state    (w_state),
        .o_vsync    (w_vsync),
        .o_href     (w_href),
        .o_fetch    (w_fetch),
        .o_load_low (w_load_low)
    );

    // A missing pixel still occupies its two byte slots (filled) so line
    // timing never stretches; the stream simply resumes at the next slot.
    always_ff @(posedge p_clock or posedge reset) begin
        if (reset) begin
            r_p_data   <= CAM_FILL_BYTE;
            r_low      <= CAM_FILL_BYTE;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_fetch) begin
                if (in_valid) begin
                    r_p_data <= in_data[15:8];
                    r_low    <= in_data[7:0];
                end else begin
                    r_p_data   <= CAM_FILL_BYTE;
                    r_low      <= CAM_FILL_BYTE;
                    r_underrun <= 1'b1;
                end
            end else if (w_load_low) begin
                r_p_data <= r_low;
            end else begin
                r_p_data <= CAM_FILL_BYTE;
            end
        end
    end

    assign in_ready = w_fetch;
    assign vsync    = w_vsync;
    assign href     = w_href;
    assign p_data   = r_p_data;
    assign underrun = r_underrun;
    assign busy     = (w_state != ST_IDLE);

endmodule

// File: tb/tb_camera_emulator.sv
module tb_camera_emulator;

    localparam int H  = 4;
    localparam int HB = 3;
    localparam int VA = 2;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int L  = 2 * H + HB;
    localparam int F  = (VS + VB + VA + VF) * L;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        vsync;
    logic        href;
    logic [7:0]  p_data;
    logic        underrun;
    logic        busy;

    camera_emulator #(
        .H_ACTIVE    (H),
        .H_BLANK     (HB),
        .V_ACTIVE    (VA),
        .VSYNC_LINES (VS),
        .V_BACK      (VB),
        .V_FRONT     (VF)
    ) dut (
        .p_clock  (clk),
        .reset    (rst),
        .enable   (enable),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .vsync    (vsync),
        .href     (href),
        .p_data   (p_data),
        .underrun (underrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: position within the frame as a plain cycle index.
    bit         m_run;
    int         m_t;
    logic [7:0] m_lo;

    int         mode;       // 0: table pixels, 1: random pixels
    bit         drop_en;
    int         pix_idx;
    logic [15:0] pix_tab [8];

    int         ready_cnt;
    int         under_cnt;
    int         busy_cnt;
    logic [7:0] cap [8];
    int         cyc;
    int         last_rise;
    bit         chk_b2b;
    logic       prev_vs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit          n_run;
        int          n_t, n_line, n_b, k;
        bit          n_href, e_ready, e_u;
        logic        v;
        logic [15:0] d;
        logic [7:0]  e_p;
        #1;
        if (!m_run || m_t == F - 1) begin
            n_run = enable;
            n_t   = 0;
        end else begin
            n_run = 1'b1;
            n_t   = m_t + 1;
        end
        n_line  = n_t / L;
        n_b     = n_t % L;
        n_href  = n_run && (n_line >= VS + VB) && (n_line < VS + VB + VA) && (n_b < 2 * H);
        e_ready = n_href && (n_b % 2 == 0);
        k       = (n_line - VS - VB) * H + n_b / 2;
        if (mode == 0) begin
            in_data  = pix_tab[pix_idx % 8];
            in_valid = !(drop_en && e_ready && k == 2);
        end else begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 16'($urandom);
        end
        check("in_ready", in_ready, e_ready);
        if (in_ready) ready_cnt++;
        v = in_valid;
        d = in_data;
        @(posedge clk);
        #1;
        cyc++;
        e_u = 1'b0;
        if (e_ready) begin
            e_p  = v ? d[15:8] : 8'h00;
            m_lo = v ? d[7:0] : 8'h00;
            e_u  = !v;
        end else if (n_href) begin
            e_p = m_lo;
        end else begin
            e_p = 8'h00;
        end
        check("vsync", vsync, n_run && (n_line < VS));
        check("href", href, n_href);
        check("p_data", p_data, e_p);
        check("underrun", underrun, e_u);
        check("busy", busy, n_run);
        if (underrun) under_cnt++;
        if (busy) busy_cnt++;
        if (n_run && n_line == VS + VB && n_b < 2 * H) cap[n_b] = p_data;
        if (vsync && !prev_vs) begin
            if (chk_b2b && last_rise >= 0) check("vsync_period", cyc - last_rise, F);
            last_rise = cyc;
        end
        prev_vs = vsync;
        if (mode == 0 && e_ready && v) pix_idx++;
        m_run = n_run;
        m_t   = n_t;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vsync"}, vsync, 1'b0);
        check({tag, "_href"}, href, 1'b0);
        check({tag, "_p_data"}, p_data, 8'h00);
        check({tag, "_underrun"}, underrun, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        pix_tab[0] = 16'h1234; pix_tab[1] = 16'h5678;
        pix_tab[2] = 16'h9ABC; pix_tab[3] = 16'hDEF0;
        pix_tab[4] = 16'h0FED; pix_tab[5] = 16'hCBA9;
        pix_tab[6] = 16'h8765; pix_tab[7] = 16'h4321;
        m_run = 1'b0; m_t = 0; m_lo = 8'h00;
        mode = 0; drop_en = 1'b0; pix_idx = 0;
        ready_cnt = 0; under_cnt = 0; busy_cnt = 0;
        cyc = 0; last_rise = -1; chk_b2b = 1'b1; prev_vs = 1'b0;
        for (int i = 0; i < 8; i++) cap[i] = 8'hXX;

        // Reset state
        rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");

        // Frame 1: byte order with table pixels, in_valid held high
        enable = 1'b1;
        rst    = 1'b0;
        ready_cnt = 0;
        repeat (F) cycle();
        check("ready_per_frame", ready_cnt, 8);
        check("line0_b0", cap[0], 8'h12);
        check("line0_b1", cap[1], 8'h34);
        check("line0_b2", cap[2], 8'h56);
        check("line0_b3", cap[3], 8'h78);
        check("line0_b4", cap[4], 8'h9A);
        check("line0_b5", cap[5], 8'hBC);
        check("line0_b6", cap[6], 8'hDE);
        check("line0_b7", cap[7], 8'hF0);

        // Frame 2: underrun on pixel 2 of line 0
        drop_en = 1'b1;
        ready_cnt = 0; under_cnt = 0;
        repeat (F) cycle();
        drop_en = 1'b0;
        check("ur_ready_per_frame", ready_cnt, 8);
        check("ur_pulses", under_cnt, 1);
        check("ur_b0", cap[0], 8'h12);
        check("ur_b4", cap[4], 8'h00);
        check("ur_b5", cap[5], 8'h00);
        check("ur_b6", cap[6], 8'h9A);
        check("ur_b7", cap[7], 8'hBC);

        // Random pixels and valid gaps over back-to-back frames
        mode = 1;
        repeat (4 * F) cycle();

        // Enable drop at cycle 20 of a frame
        chk_b2b = 1'b0;
        busy_cnt = 0;
        repeat (20) cycle();
        enable = 1'b0;
        repeat (F - 20) cycle();
        ready_cnt = 0;
        repeat (20) cycle();
        check("drop_busy_cycles", busy_cnt, F);
        check("drop_ready_idle", ready_cnt, 0);
        check("drop_busy", busy, 1'b0);
        check("drop_vsync", vsync, 1'b0);

        // Reset in the middle of an active line (byte 3)
        enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (m_run && (m_t / L == VS + VB) && (m_t % L == 3)) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_byte3", found, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        m_run = 1'b0; m_t = 0; m_lo = 8'h00;
        prev_vs = 1'b0; last_rise = -1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        check("post_rst_vsync", vsync, 1'b1);
        chk_b2b = 1'b1;
        repeat (F + 10) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
